// File: rtl/gbsha_fir_serializer.sv
// Buffers signed FIR output samples in a small FIFO and streams each one MSB-first
// on a single pin with a frame strobe; a sticky flag records dropped samples.
module gbsha_fir_serializer #(
    parameter int BW_sample = 3,
    parameter int DEPTH     = 4,
    parameter int GAP       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    input  logic [BW_sample-1:0]    s_data,
    output logic                    s_ready,
    input  logic                    clr_ovf,
    output logic                    ser_out,
    output logic                    ser_frame,
    output logic                    busy,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (BW_sample > 1) ? $clog2(BW_sample) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_TOP  = CW'(BW_sample - 1);
    localparam logic [GW-1:0] GAP_TOP  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    // IDLE: wait for a sample | SHIFT: send bits MSB-first | GAP: idle bit periods
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t                 state_q, state_d;
    logic [BW_sample-1:0]   mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q, level_d;
    logic [BW_sample-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    logic                   ser_out_q, ser_frame_q, busy_q, overflow_q;
    logic                   empty, full, push, drop, pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    assign push  = s_valid && !full;
    assign drop  = s_valid && full;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = GAP_TOP;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            shreg_d = mem_q[rd_ptr_q];
            cnt_d   = CNT_TOP;
            state_d = ST_SHIFT;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + (AW + 1)'(1);
        else if (!push && pop) level_d = level_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wr_ptr_q] <= s_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            // Serial outputs lag the FSM by one register stage
            ser_out_q   <= (state_q == ST_SHIFT) && shreg_q[BW_sample-1];
            ser_frame_q <= (state_q == ST_SHIFT) && (cnt_q == CNT_TOP);
            busy_q      <= (state_d != ST_IDLE);
            if (drop)         overflow_q <= 1'b1;
            else if (clr_ovf) overflow_q <= 1'b0;
        end
    end

    assign s_ready   = !full;
    assign ser_out   = ser_out_q;
    assign ser_frame = ser_frame_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: tb/tb_gbsha_fir_serializer.sv
// Self-checking bench for gbsha_fir_serializer: scoreboard of accepted samples
// against frames reassembled from the serial pin, plus cycle-exact checks.
module tb_gbsha_fir_serializer;

    localparam int BW    = 3;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [2:0] s_data = '0;
    logic       clr_ovf = 1'b0;
    logic       s_ready, ser_out, ser_frame, busy, overflow;
    logic [2:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] rx_q[$];
    logic [2:0] cap;
    int         cap_n = 0;

    gbsha_fir_serializer #(.BW_sample(BW), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .clr_ovf(clr_ovf), .ser_out(ser_out),
        .ser_frame(ser_frame), .busy(busy), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    // Reassemble frames from the serial pin
    always @(negedge clk) begin
        if (reset) begin
            cap_n = 0;
        end else if (ser_frame) begin
            cap   = {2'b00, ser_out};
            cap_n = 1;
        end else if (cap_n > 0) begin
            cap   = {cap[1:0], ser_out};
            cap_n = cap_n + 1;
        end
        if (cap_n == BW) begin
            rx_q.push_back(cap);
            cap_n = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_ready, level, ser_out, ser_frame, busy, overflow} !== {1'b1, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b",
                     {s_ready, level, ser_out, ser_frame, busy, overflow}, 8'b1000_0000);
        end
        reset = 1'b0;
        @(negedge clk); s_valid = 1'b1; s_data = 3'b111;
        @(negedge clk); s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({ser_out, ser_frame} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pre_msb: got %b want 11", {ser_out, ser_frame});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({s_ready, level, ser_out, ser_frame, busy, overflow} !== {1'b1, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b",
                     {s_ready, level, ser_out, ser_frame, busy, overflow}, 8'b1000_0000);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_single();
        logic [3:0] bits = 4'b1010;
        logic [3:0] frm  = 4'b1000;
        logic [2:0] e, r;
        repeat (2) @(negedge clk);
        s_valid = 1'b1; s_data = 3'b101; exp_q.push_back(3'b101);
        @(negedge clk); s_valid = 1'b0;
        n_tests++;
        if ({level, busy} !== {3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_no_bypass: got level=%0d busy=%b want level=1 busy=0", level, busy);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ser_out, ser_frame} !== {bits[3-i], frm[3-i]}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got out/frame=%b%b want %b%b",
                         i, ser_out, ser_frame, bits[3-i], frm[3-i]);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_end: got %b want 0", busy);
        end
        for (int c = 0; c < 40 && rx_q.size() < 1; c++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_sb_missing: got nothing want %b", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    n_fail++;
                    $display("FAIL single_sb: got %b want %b", r, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] want = 7'b0110100;
        logic [6:0] got;
        logic [2:0] peak = '0;
        logic [2:0] e, r;
        repeat (2) @(negedge clk);
        s_valid = 1'b1; s_data = 3'b011; exp_q.push_back(3'b011);
        @(negedge clk);
        if (level > peak) peak = level;
        s_data = 3'b100; exp_q.push_back(3'b100);
        @(negedge clk);
        if (level > peak) peak = level;
        s_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (level > peak) peak = level;
            got[6-i] = ser_out;
        end
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL b2b_stream: got %b want %b", got, want);
        end
        n_tests++;
        if (peak !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_level_peak: got %0d want 1", peak);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %b want 0", overflow);
        end
        for (int c = 0; c < 40 && rx_q.size() < 2; c++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_sb_missing: got nothing want %b", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    n_fail++;
                    $display("FAIL b2b_sb: got %b want %b", r, e);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rdy_exp = 8'b0101_1111;
        logic [2:0] e, r;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            s_valid = 1'b1; s_data = 3'(i);
            n_tests++;
            if (s_ready !== rdy_exp[i]) begin
                n_fail++;
                $display("FAIL ovf_ready%0d: got %b want %b", i, s_ready, rdy_exp[i]);
            end
            if (rdy_exp[i]) exp_q.push_back(3'(i));
        end
        @(negedge clk); s_valid = 1'b0;
        n_tests++;
        if ({level, s_ready, overflow} !== {3'd4, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_full: got level=%0d ready=%b ovf=%b want 4 0 1", level, s_ready, overflow);
        end
        for (int c = 0; c < 80 && rx_q.size() < 6; c++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL ovf_sb_missing: got nothing want %b", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    n_fail++;
                    $display("FAIL ovf_sb: got %b want %b", r, e);
                end
            end
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (rx_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_extra: got extra=%0d busy=%b want 0 0", rx_q.size(), busy);
        end
    endtask

    task automatic test_clr_ovf();
        logic [7:0] rdy_exp = 8'b0101_1111;
        logic [2:0] e, r;
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_not_full: got %b want 0", overflow);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) begin
                n_tests++;
                if (overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clr_pre_drop: got %b want 0", overflow);
                end
            end
            if (i == 6) begin
                n_tests++;
                if (overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clr_with_drop: got %b want 1", overflow);
                end
            end
            s_valid = 1'b1; s_data = 3'(7 - i); clr_ovf = (i >= 5);
            if (rdy_exp[i]) exp_q.push_back(3'(7 - i));
        end
        @(negedge clk); s_valid = 1'b0; clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_after_drop: got %b want 0", overflow);
        end
        for (int c = 0; c < 80 && rx_q.size() < 6; c++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL clr_sb_missing: got nothing want %b", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    n_fail++;
                    $display("FAIL clr_sb: got %b want %b", r, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] bits = 3'b110;
        logic [2:0] frm  = 3'b100;
        logic [2:0] e, r;
        repeat (8) @(negedge clk);
        s_valid = 1'b1; s_data = 3'b111;
        @(negedge clk); s_data = 3'b010;
        @(negedge clk); s_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if ({ser_out, ser_frame} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_second_bit: got %b want 10", {ser_out, ser_frame});
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if ({s_ready, level, ser_out, ser_frame, busy, overflow} !== {1'b1, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want %b",
                     {s_ready, level, ser_out, ser_frame, busy, overflow}, 8'b1000_0000);
        end
        exp_q.delete();
        @(negedge clk);
        rx_q.delete();
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_data = 3'b110; exp_q.push_back(3'b110);
        @(negedge clk); s_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ser_out, ser_frame} !== {bits[2-i], frm[2-i]}) begin
                n_fail++;
                $display("FAIL mid_clean_bit%0d: got out/frame=%b%b want %b%b",
                         i, ser_out, ser_frame, bits[2-i], frm[2-i]);
            end
        end
        for (int c = 0; c < 40 && rx_q.size() < 1; c++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL mid_sb_missing: got nothing want %b", e);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    n_fail++;
                    $display("FAIL mid_sb: got %b want %b", r, e);
                end
            end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (rx_q.size() != 0 || busy !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_stale: got extra=%0d busy=%b level=%0d want 0 0 0", rx_q.size(), busy, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clr_ovf();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
